// File: rtl/xor_gate_pkg.sv
// xor_gate_pkg: shared defaults and saturating-increment helper for the XOR difference unit
package xor_gate_pkg;
  localparam int XOR_WIDTH_DEF = 1;
  localparam int XOR_CNT_W_DEF = 16;
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
    logic [63:0] max;
    max = (width >= 64) ? '1 : (64'(1) << width) - 64'(1);
    return (value >= max) ? max : value + 64'(1);
  endfunction
endpackage

// File: rtl/xor_gate_core_sat_counter.sv
// sat_counter: saturating event counter, priority rst > clr > inc
module sat_counter
  import xor_gate_pkg::*;
#(
  parameter int CNT_W = XOR_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q, count_d;
  if (CNT_W < 1 || CNT_W > 64) begin : g_bad_cnt_w
    $error("sat_counter: CNT_W must be in 1..64");
  end
  always_comb begin
    count_d = clr ? '0 : inc ? CNT_W'(sat_inc(64'(count_q), CNT_W)) : count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end
  assign count = count_q;
endmodule

// File: rtl/xor_gate_core.sv
// xor_gate_core: bitwise XOR with registered copy, reduction flags and saturating difference count
module xor_gate_core
  import xor_gate_pkg::*;
#(
  parameter int WIDTH = XOR_WIDTH_DEF,
  parameter int CNT_W = XOR_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             clr,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  output logic             diff_any,
  output logic             parity,
  output logic [CNT_W-1:0] diff_count
);
  logic [WIDTH-1:0] y_d;
  logic             valid_q, valid_d;
  if (WIDTH < 1) begin : g_bad_width
    $error("xor_gate_core: WIDTH must be >= 1");
  end
  assign y = a ^ b;
  always_comb begin
    y_d     = in_valid ? y : y_q;
    valid_d = in_valid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end
  assign out_valid = valid_q;
  assign diff_any  = |y_q;
  assign parity    = ^y_q;
  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (in_valid & (|y)),
    .count (diff_count)
  );
endmodule

// File: tb/tb_xor_gate_core.sv
// tb_xor_gate_core: randomized and directed checks of three xor_gate_core configurations against a behavioural model
module tb_xor_gate_core;
  logic       clk = 0, rst = 1, in_valid = 0, clr = 0;
  logic [7:0] a8 = 0, b8 = 0;
  int         passed = 0, total = 0;
  logic        y1, yq1, ov1, da1, p1;
  logic [15:0] c1;
  logic [7:0]  y8, yq8;
  logic        ov8, da8, p8;
  logic [15:0] c8;
  logic [7:0]  y2, yq2;
  logic        ov2, da2, p2;
  logic [1:0]  c2;
  always #5 clk = ~clk;

  xor_gate_core u1 (.clk(clk), .rst(rst), .a(a8[0]), .b(b8[0]), .in_valid(in_valid), .clr(clr),
    .y(y1), .y_q(yq1), .out_valid(ov1), .diff_any(da1), .parity(p1), .diff_count(c1));
  xor_gate_core #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(in_valid), .clr(clr),
    .y(y8), .y_q(yq8), .out_valid(ov8), .diff_any(da8), .parity(p8), .diff_count(c8));
  xor_gate_core #(.WIDTH(8), .CNT_W(2)) u2 (.clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(in_valid), .clr(clr),
    .y(y2), .y_q(yq2), .out_valid(ov2), .diff_any(da2), .parity(p2), .diff_count(c2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // model: index 0 = WIDTH 1, 1 = WIDTH 8, 2 = WIDTH 8 with 2-bit counter
  int mask [3] = '{1, 255, 255};
  int cmax [3] = '{65535, 65535, 3};
  int m_yq [3], m_ov [3], m_cnt [3];
  bit known = 0;
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int d;
      d = (a8 ^ b8) & mask[k];
      if (rst) begin
        m_yq[k] = 0; m_ov[k] = 0; m_cnt[k] = 0;
      end else begin
        m_ov[k] = in_valid;
        if (in_valid) m_yq[k] = d;
        if (clr) m_cnt[k] = 0;
        else if (in_valid && d != 0 && m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
      end
    end
    if (rst) known = 1;
  end

  always @(negedge clk) begin
    chk("y1", 32'(y1), 32'((a8 ^ b8) & 8'h1));
    chk("y8", 32'(y8), 32'(a8 ^ b8));
    if (known) begin
      chk("yq1", 32'(yq1), m_yq[0]);
      chk("ov1", 32'(ov1), m_ov[0]);
      chk("any1", 32'(da1), 32'(m_yq[0] != 0));
      chk("par1", 32'(p1), $countones(m_yq[0]) % 2);
      chk("cnt1", 32'(c1), m_cnt[0]);
      chk("yq8", 32'(yq8), m_yq[1]);
      chk("ov8", 32'(ov8), m_ov[1]);
      chk("any8", 32'(da8), 32'(m_yq[1] != 0));
      chk("par8", 32'(p8), $countones(m_yq[1]) % 2);
      chk("cnt8", 32'(c8), m_cnt[1]);
      chk("yq2", 32'(yq2), m_yq[2]);
      chk("ov2", 32'(ov2), m_ov[2]);
      chk("cnt2", 32'(c2), m_cnt[2]);
    end
  end

  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic iv, input logic c, input logic r);
    a8 = a; b8 = b; in_valid = iv; clr = c; rst = r;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] tt;
    int sat_exp [5] = '{1, 2, 3, 3, 3};
    tt = 4'b0110;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("rst_yq", 32'(yq8), 0);
    chk("rst_ov", 32'(ov8), 0);
    chk("rst_cnt", 32'(c8), 0);
    for (int i = 0; i < 4; i++) begin
      a8 = {7'b0, 1'(i >> 1)}; b8 = {7'b0, 1'(i)};
      #1 chk("truth_y", 32'(y1), 32'(tt[i]));
    end
    step(8'hF0, 8'h3C, 1, 0, 0);
    chk("lat_yq", 32'(yq8), 32'hCC);
    chk("lat_ov", 32'(ov8), 1);
    chk("lat_any", 32'(da8), 1);
    chk("lat_par", 32'(p8), 0);
    chk("lat_cnt", 32'(c8), 1);
    step(8'hF0, 8'h3C, 0, 0, 0);
    chk("idle_ov", 32'(ov8), 0);
    chk("idle_yq", 32'(yq8), 32'hCC);
    step(8'hA5, 8'hA5, 1, 0, 0);
    chk("eq_yq", 32'(yq8), 0);
    chk("eq_any", 32'(da8), 0);
    chk("eq_cnt", 32'(c8), 1);
    step(8'h01, 8'h00, 1, 0, 0);
    chk("one_par", 32'(p8), 1);
    chk("one_any", 32'(da8), 1);
    chk("one_cnt", 32'(c8), 2);
    step(0, 0, 0, 1, 0);
    chk("clr_cnt", 32'(c2), 0);
    for (int i = 0; i < 5; i++) begin
      step(8'(i + 1), 0, 1, 0, 0);
      chk("sat_cnt", 32'(c2), sat_exp[i]);
    end
    step(8'h55, 0, 1, 1, 0);
    chk("clrinc_cnt", 32'(c2), 0);
    chk("clrinc_yq", 32'(yq2), 32'h55);
    step(8'hFF, 8'hF0, 1, 0, 0);
    step(8'hFF, 8'hF0, 1, 0, 0);
    chk("pre_rst_cnt", 32'(c8), 2);
    chk("pre_rst_yq", 32'(yq8), 32'h0F);
    step(8'h01, 8'h02, 1, 0, 1);
    chk("mid_rst_yq", 32'(yq8), 0);
    chk("mid_rst_ov", 32'(ov8), 0);
    chk("mid_rst_cnt", 32'(c8), 0);
    step(8'h03, 8'h05, 1, 0, 0);
    chk("post_rst_ov", 32'(ov8), 1);
    chk("post_rst_yq", 32'(yq8), 32'h06);
    for (int i = 0; i < 1000; i++)
      step(8'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 1)) : 8'($urandom),
           1'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
    step(0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
